// File: rtl/alu_result_sched.sv
// alu_result_sched: round-robin scheduler that shares one 8:1 ALU result
// selector among NREQ requesters. An accepted op drives the selector ctl,
// waits out the lane's settle latency, captures the result and returns it
// tagged with the owner's id. One operation in flight at a time.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. req_ready is a one-hot grant offered only
// in IDLE; rsp_valid/rsp_id/rsp_data stay stable until rsp_ready is seen.
module alu_result_sched #(
  parameter int          NREQ        = 4,
  parameter logic [7:0]  SLOW_MASK   = 8'h00,
  parameter int          SLOW_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [3*NREQ-1:0]         req_op,
  output logic [NREQ-1:0]           req_ready,
  output logic [2:0]                res_ctl,
  input  logic [31:0]               res_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [31:0]               rsp_data,
  output logic                      busy
);

  localparam int ID_W  = $clog2(NREQ);
  // counter holds lat-1, so it only needs to reach SLOW_CYCLES-1
  localparam int CNT_W = (SLOW_CYCLES > 1) ? $clog2(SLOW_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  cnt;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [2:0]        grant_op;
  logic [CNT_W-1:0]  grant_cnt;
  logic [ID_W-1:0]   rr_next;
  logic [ID_W:0]     scan_sum;
  logic [ID_W-1:0]   scan_idx;

  // round-robin search starting at rr_ptr, wrapping modulo NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      scan_idx = (scan_sum >= (ID_W+1)'(NREQ)) ? ID_W'(scan_sum - (ID_W+1)'(NREQ))
                                                : scan_sum[ID_W-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  // lane select, settle count and next pointer for the granted requester
  always_comb begin
    grant_op  = req_op[3*int'(grant_id) +: 3];
    grant_cnt = SLOW_MASK[grant_op] ? CNT_W'(SLOW_CYCLES - 1) : '0;
    rr_next   = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
  end

  // next-state logic and combinational outputs
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nxt = WAIT;
          // grant is withheld while reset is asserted
          if (rst_n) req_ready[grant_id] = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // datapath: capture op on accept, count down settle, capture result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ctl   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            res_ctl <= grant_op;
            rsp_id  <= grant_id;
            rr_ptr  <= rr_next;
            cnt     <= grant_cnt;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= res_data;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_sched.sv
// tb_alu_result_sched: randomized bench with a behavioural reference model
// for the round-robin result scheduler (grant order, lane latency, captured
// data, response hold and reset abort).
module tb_alu_result_sched;

  localparam int         NREQ        = 4;
  localparam int         ID_W        = 2;
  localparam logic [7:0] SLOW_MASK   = 8'h88;
  localparam int         SLOW_CYCLES = 4;
  localparam int         W           = ID_W + 32;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [3*NREQ-1:0]    req_op;
  logic [NREQ-1:0]      req_ready;
  logic [2:0]           res_ctl;
  logic [31:0]          res_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [31:0]          rsp_data;
  logic                 busy;

  int                   n_checks = 0;
  int                   n_pass   = 0;
  int                   rr_model = 0;
  logic [W-1:0]         exp_q[$];
  logic [W-1:0]         mon_e;

  alu_result_sched #(
    .NREQ        (NREQ),
    .SLOW_MASK   (SLOW_MASK),
    .SLOW_CYCLES (SLOW_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .res_ctl   (res_ctl),
    .res_data  (res_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model: first requester at or after the pointer, modulo NREQ
  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic int model_lat(input logic [2:0] op);
    return SLOW_MASK[op] ? SLOW_CYCLES : 1;
  endfunction

  // scoreboard: every response handshake must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", rsp_id, mon_e[W-1:32]);
        check("rsp_data", rsp_data, mon_e[31:0]);
      end
    end
  end

  // driver: one full operation. Entered and left #1 after a rising edge
  // with the DUT idle. mode 0 random data, 1 ramp 1..lat, 2 DEADBEEF.
  task automatic do_op(input logic [NREQ-1:0] valid, input logic [3*NREQ-1:0] ops,
                       input int hold, input int mode);
    int              id;
    int              lat;
    logic [2:0]      op;
    logic [NREQ-1:0] oh;
    logic [31:0]     d;
    id  = model_grant(valid, rr_model);
    op  = ops[3*id +: 3];
    lat = model_lat(op);
    oh  = '0;
    oh[id] = 1'b1;
    d   = '0;
    req_valid = valid;
    req_op    = ops;
    rsp_ready = (hold == 0);
    res_data  = $urandom;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("grant", req_ready, oh);
    @(posedge clk); #1;
    rr_model = (id + 1) % NREQ;
    check("res_ctl", res_ctl, op);
    check("busy", busy, 1);
    req_valid = NREQ'($urandom);
    for (int e = 1; e <= lat; e++) begin
      case (mode)
        1:       d = 32'(e);
        2:       d = 32'hDEADBEEF;
        default: d = $urandom;
      endcase
      res_data = d;
      if (hold != 0) rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("wait_valid", rsp_valid, 0);
      check("wait_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    exp_q.push_back({ID_W'(id), d});
    check("rsp_valid", rsp_valid, 1);
    check("res_ctl_held", res_ctl, op);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      req_valid = '1;
      res_data  = $urandom;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_id", rsp_id, id);
      check("hold_data", rsp_data, d);
      check("hold_ctl", res_ctl, op);
      check("hold_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_valid", rsp_valid, 0);
    check("post_busy", busy, 0);
    check("post_data", rsp_data, d);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_op    = '0;
    res_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_ctl", res_ctl, 0);
    check("rst_id", rsp_id, 0);
    check("rst_data", rsp_data, 0);
    rst_n     = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    check("idle_noreq_ready", req_ready, 0);
    check("idle_noreq_busy", busy, 0);

    // single requester, fast lane 5
    do_op(4'b0001, {3'd1, 3'd2, 3'd3, 3'd5}, 0, 2);

    // all requesting, consumer always ready: pure rotation
    for (int i = 0; i < 6; i++) do_op(4'b1111, 12'($urandom), 0, 0);

    // slow lane 7 with a ramping result, only last value captured
    do_op(NREQ'($urandom_range(1, 15)), {4{3'd7}}, 0, 1);

    // consumer stalls ten cycles in RESP
    do_op(4'b1111, 12'($urandom), 10, 0);

    // pointer lands on 3, single request at 2 forces a wrap
    do_op(4'b0100, 12'($urandom), 0, 0);
    do_op(4'b0100, 12'($urandom), 0, 0);
    do_op(4'b1111, 12'($urandom), 1, 0);

    // reset in the middle of a slow op: nothing may come out of it
    req_valid = '1;
    req_op    = {4{3'd7}};
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("t1_busy", busy, 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("t1_valid", rsp_valid, 0);
    check("t1_ctl", res_ctl, 0);
    check("t1_busy0", busy, 0);
    check("t1_ready", req_ready, 0);
    @(posedge clk); #1;
    check("t1_ready_held", req_ready, 0);
    rst_n    = 1'b1;
    rr_model = 0;
    do_op(4'b1111, 12'($urandom), 0, 0);

    // random traffic
    for (int i = 0; i < 40; i++)
      do_op(NREQ'($urandom_range(1, 15)), 12'($urandom), $urandom_range(0, 3), 0);

    repeat (2) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
